// File: rtl/mem_pkg.sv
// Shared types and constants for the memory arbiter slice.
package mem_pkg;

    // Arbiter FSM: either free to grant, or waiting on one outstanding read.
    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_e;

    // Which requester owns the outstanding read.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    // Access size used for every instruction fetch.
    localparam logic [2:0] FUNC3_WORD = 3'b010;

    // One memory-port command, built from the winning requester.
    typedef struct packed {
        logic        en;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [2:0]  func3;
    } mem_cmd_t;

endpackage

// File: rtl/arb_starve_guard.sv
// Priority decision between fetch and data. Data normally wins, but a run of
// MAX_D_BURST data grants while fetch is waiting hands the next grant to fetch.
module arb_starve_guard
    import mem_pkg::*;
#(
    parameter int MAX_D_BURST = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic d_req,
    input  logic grant_en,
    output logic sel_if,
    output logic sel_d
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_D_BURST);

    logic [3:0] burst_cnt_q;
    logic [3:0] burst_cnt_d;
    logic       starved;

    // Pick the winner and work out the next burst count.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        starved     = if_req && (burst_cnt_q == BURST_MAX);
        sel_d       = grant_en && d_req && !starved;
        sel_if      = grant_en && if_req && !sel_d;
        burst_cnt_d = burst_cnt_q;

        if (sel_if) begin
            burst_cnt_d = '0;
        end else if (sel_d) begin
            if (!if_req) begin
                burst_cnt_d = '0;
            end else if (burst_cnt_q < BURST_MAX) begin
                burst_cnt_d = burst_cnt_q + 4'd1;
            end
        end
    end

    // Burst counter register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        if (!reset) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port BRAM arbiter between instruction fetch and data load/store.
// Grants one access at a time from IDLE, tracks the single outstanding read
// and routes its data back to the owner with a one-cycle rvalid pulse.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int MAX_D_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic [2:0]  d_func3,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] d_rdata,

    output logic        mem_en,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [2:0]  mem_func3,
    input  logic [63:0] mem_rdata,

    output logic        busy
);

    localparam logic [1:0] LAT_INIT = 2'(MEM_LATENCY - 1);

    state_e     state_q,     state_d;
    logic [1:0] lat_cnt_q,   lat_cnt_d;
    owner_e     owner_q,     owner_d;
    logic       addr2_q,     addr2_d;
    logic       if_rvalid_q, if_rvalid_d;
    logic       d_rvalid_q,  d_rvalid_d;

    logic       grant_en;
    logic       sel_if;
    logic       sel_d;
    logic       rd_grant;
    mem_cmd_t   cmd;

    // Grants only from IDLE, and never while reset is held low.
    assign grant_en = reset && (state_q == IDLE);

    arb_starve_guard #(
        .MAX_D_BURST (MAX_D_BURST)
    ) u_starve_guard (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .d_req    (d_req),
        .grant_en (grant_en),
        .sel_if   (sel_if),
        .sel_d    (sel_d)
    );

    assign if_gnt   = sel_if;
    assign d_gnt    = sel_d;
    assign rd_grant = sel_if || (sel_d && !d_we);

    // State, latency counter, owner/address latches and rvalid pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            lat_cnt_q   <= '0;
            owner_q     <= OWN_IF;
            addr2_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            owner_q     <= owner_d;
            addr2_q     <= addr2_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
        end
    end

    // Next state: a read grant enters RD_WAIT, the return cycle goes back.
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        owner_d     = owner_q;
        addr2_d     = addr2_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (rd_grant) begin
                    state_d   = RD_WAIT;
                    lat_cnt_d = LAT_INIT;
                    owner_d   = sel_d ? OWN_D : OWN_IF;
                    addr2_d   = sel_d ? d_addr[2] : if_addr[2];
                end
            end
            RD_WAIT: begin
                if (lat_cnt_q != 2'd0) begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Arm the pulse one edge early so it is high exactly in the return cycle.
        if ((state_d == RD_WAIT) && (lat_cnt_d == 2'd0)) begin
            if_rvalid_d = (owner_d == OWN_IF);
            d_rvalid_d  = (owner_d == OWN_D);
        end
    end

    // Outputs: memory command from the winner, read data routed to the owner.
    always_comb begin
        cmd = '0;
        if (sel_d) begin
            cmd.en    = 1'b1;
            cmd.we    = d_we;
            cmd.addr  = d_addr;
            cmd.wdata = d_wdata;
            cmd.func3 = d_func3;
        end else if (sel_if) begin
            cmd.en    = 1'b1;
            cmd.we    = 1'b0;
            cmd.addr  = if_addr;
            cmd.func3 = FUNC3_WORD;
        end
    end

    assign mem_en    = cmd.en;
    assign mem_we    = cmd.we;
    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;
    assign mem_func3 = cmd.func3;

    // Read data is held at zero outside its valid pulse, including in reset.
    assign if_rdata  = if_rvalid_q ? (addr2_q ? mem_rdata[63:32] : mem_rdata[31:0]) : 32'd0;
    assign d_rdata   = d_rvalid_q ? mem_rdata : 64'd0;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign busy      = (state_q == RD_WAIT);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (latency 1 / burst 4 and latency 2 /
// burst 3) run in lockstep against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int NI   = 2;
    localparam int LAT0 = 1;
    localparam int LAT1 = 2;
    localparam int MB0  = 4;
    localparam int MB1  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_l     [NI];
    logic        if_req    [NI];
    logic [63:0] if_addr   [NI];
    logic        if_gnt    [NI];
    logic        if_rvalid [NI];
    logic [31:0] if_rdata  [NI];
    logic        d_req     [NI];
    logic        d_we      [NI];
    logic [63:0] d_addr    [NI];
    logic [63:0] d_wdata   [NI];
    logic [2:0]  d_func3   [NI];
    logic        d_gnt     [NI];
    logic        d_rvalid  [NI];
    logic [63:0] d_rdata   [NI];
    logic        mem_en    [NI];
    logic        mem_we    [NI];
    logic [63:0] mem_addr  [NI];
    logic [63:0] mem_wdata [NI];
    logic [2:0]  mem_func3 [NI];
    logic [63:0] mem_rdata [NI];
    logic        busy      [NI];

    mem_arbiter #(.MEM_LATENCY(LAT0), .MAX_D_BURST(MB0)) u_dut0 (
        .clk(clk), .reset(rst_l[0]),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
        .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_func3(d_func3[0]), .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_func3(mem_func3[0]), .mem_rdata(mem_rdata[0]),
        .busy(busy[0])
    );

    mem_arbiter #(.MEM_LATENCY(LAT1), .MAX_D_BURST(MB1)) u_dut1 (
        .clk(clk), .reset(rst_l[1]),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
        .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_func3(d_func3[1]), .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_func3(mem_func3[1]), .mem_rdata(mem_rdata[1]),
        .busy(busy[1])
    );

    // Reference model state, per instance.
    int          lat_m   [NI];
    int          mb_m    [NI];
    int          rd_left [NI];   // cycles until the read returns; 0 = free
    int          burst   [NI];   // data grants in a row while fetch waits
    bit          own_d   [NI];
    logic [63:0] rd_addr [NI];
    bit          m_if_gnt[NI];
    bit          m_d_gnt [NI];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Memory contents seen by reads; the 0x10 doubleword holds a fixed pattern.
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        if (a[63:3] == 61'h2) return 64'hAAAA_BBBB_CCCC_DDDD;
        return {a[31:0] ^ 32'h1234_5678, ~a[31:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive memory data, compare every output, advance model.
    task automatic tick();
        logic [63:0] ret_data [NI];
        for (int k = 0; k < NI; k++) begin
            ret_data[k]  = mem_word(rd_addr[k]);
            mem_rdata[k] = (rst_l[k] && rd_left[k] == 1) ? ret_data[k] : {$urandom(), $urandom()};
        end
        #1;
        for (int k = 0; k < NI; k++) begin
            bit          e_ig, e_dg, e_ir, e_dr, e_busy, e_en, e_we, ret, starved;
            logic [63:0] e_addr, e_wdata;
            logic [2:0]  e_f3;
            e_ig = 0; e_dg = 0; e_ir = 0; e_dr = 0; e_busy = 0; e_en = 0; e_we = 0; ret = 0;
            e_addr = '0; e_wdata = '0; e_f3 = '0;

            if (!rst_l[k]) begin
                rd_left[k] = 0;
                burst[k]   = 0;
                check($sformatf("i%0d_rst_if_rdata", k), 64'(if_rdata[k]), 64'd0);
                check($sformatf("i%0d_rst_d_rdata", k), d_rdata[k], 64'd0);
            end else if (rd_left[k] > 0) begin
                e_busy = 1;
                ret    = (rd_left[k] == 1);
                e_ir   = ret && !own_d[k];
                e_dr   = ret && own_d[k];
                rd_left[k]--;
            end else begin
                starved = if_req[k] && (burst[k] == mb_m[k]);
                if (d_req[k] && !starved) e_dg = 1;
                else if (if_req[k])       e_ig = 1;
                if (e_dg) begin
                    e_en = 1; e_we = d_we[k]; e_addr = d_addr[k];
                    e_wdata = d_wdata[k]; e_f3 = d_func3[k];
                    if (!if_req[k])              burst[k] = 0;
                    else if (burst[k] < mb_m[k]) burst[k]++;
                    if (!d_we[k]) begin
                        rd_left[k] = lat_m[k]; own_d[k] = 1; rd_addr[k] = d_addr[k];
                    end
                end else if (e_ig) begin
                    e_en = 1; e_addr = if_addr[k]; e_f3 = 3'b010;
                    burst[k]   = 0;
                    rd_left[k] = lat_m[k]; own_d[k] = 0; rd_addr[k] = if_addr[k];
                end
            end

            check($sformatf("i%0d_ctl{ig,dg,ir,dr,busy,en,we}", k),
                  64'({if_gnt[k], d_gnt[k], if_rvalid[k], d_rvalid[k], busy[k], mem_en[k], mem_we[k]}),
                  64'({e_ig, e_dg, e_ir, e_dr, e_busy, e_en, e_we}));
            check($sformatf("i%0d_mem_addr", k), mem_addr[k], e_addr);
            check($sformatf("i%0d_mem_wdata", k), mem_wdata[k], e_wdata);
            check($sformatf("i%0d_mem_func3", k), 64'(mem_func3[k]), 64'(e_f3));
            if (ret && own_d[k])
                check($sformatf("i%0d_d_rdata", k), d_rdata[k], ret_data[k]);
            if (ret && !own_d[k])
                check($sformatf("i%0d_if_rdata", k), 64'(if_rdata[k]),
                      64'(rd_addr[k][2] ? ret_data[k][63:32] : ret_data[k][31:0]));
            m_if_gnt[k] = e_ig;
            m_d_gnt[k]  = e_dg;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs(input int k);
        if_req[k] = 0; if_addr[k] = '0;
        d_req[k] = 0; d_we[k] = 0; d_addr[k] = '0; d_wdata[k] = '0; d_func3[k] = '0;
    endtask

    // Random requester: holds a request until granted, occasionally withdraws it.
    task automatic rand_req(input int k);
        if (if_req[k] && !m_if_gnt[k]) begin
            if ($urandom_range(9) == 0) if_req[k] = 0;
        end else begin
            if_req[k]  = 1'($urandom_range(1));
            if_addr[k] = {$urandom(), $urandom()} & ~64'h3;
        end
        if (d_req[k] && !m_d_gnt[k]) begin
            if ($urandom_range(9) == 0) d_req[k] = 0;
        end else begin
            d_req[k]   = 1'($urandom_range(1));
            d_we[k]    = 1'($urandom_range(1));
            d_addr[k]  = {$urandom(), $urandom()};
            d_wdata[k] = {$urandom(), $urandom()};
            d_func3[k] = 3'($urandom_range(7));
        end
    endtask

    initial begin
        lat_m = '{LAT0, LAT1};
        mb_m  = '{MB0, MB1};
        for (int k = 0; k < NI; k++) begin
            rd_left[k] = 0; burst[k] = 0; own_d[k] = 0; rd_addr[k] = '0;
            m_if_gnt[k] = 0; m_d_gnt[k] = 0;
            rst_l[k] = 0; mem_rdata[k] = '0;
            idle_inputs(k);
        end
        @(negedge clk);

        // Reset with requests pending: everything must stay at zero.
        if_req[0] = 1; if_addr[0] = 64'h10;
        d_req[1] = 1; d_we[1] = 1; d_addr[1] = 64'h200; d_wdata[1] = 64'h1122_3344_5566_7788;
        repeat (2) tick();

        // Lone fetch at 0x10 granted on the first cycle out of reset; store on inst 1.
        rst_l[0] = 1; rst_l[1] = 1;
        tick();
        if_req[0] = 0; d_req[1] = 0;
        repeat (2) tick();

        // Lone fetch at 0x14 returns the upper word.
        if_req[0] = 1; if_addr[0] = 64'h14;
        tick();
        if_req[0] = 0;
        repeat (2) tick();

        // Simultaneous fetch and load: load first, fetch two cycles later.
        if_req[0] = 1; if_addr[0] = 64'h20;
        d_req[0] = 1; d_we[0] = 0; d_addr[0] = 64'h40; d_func3[0] = 3'b011;
        tick();
        d_req[0] = 0;
        repeat (2) tick();
        if_req[0] = 0;
        repeat (2) tick();

        // Starvation guard: fetch held against back-to-back stores.
        if_req[0] = 1; if_addr[0] = 64'h30;
        d_req[0] = 1; d_we[0] = 1; d_addr[0] = 64'h100; d_wdata[0] = {$urandom(), $urandom()};
        for (int i = 0; i < 14; i++) begin
            tick();
            if (m_d_gnt[0]) begin
                d_addr[0]  = d_addr[0] + 64'd8;
                d_wdata[0] = {$urandom(), $urandom()};
            end
        end
        idle_inputs(0);
        repeat (3) tick();

        // Latency 2 load with a fetch pending behind it.
        if_req[1] = 1; if_addr[1] = 64'h88;
        d_req[1] = 1; d_we[1] = 0; d_addr[1] = 64'h48;
        tick();
        d_req[1] = 0;
        repeat (3) tick();
        if_req[1] = 0;
        repeat (3) tick();

        // Reset mid-read: the read is dropped; a store is granted right after release.
        if_req[1] = 1; if_addr[1] = 64'h50;
        tick();
        if_req[1] = 0; rst_l[1] = 0;
        d_req[1] = 1; d_we[1] = 1; d_addr[1] = 64'h58; d_wdata[1] = 64'hDEAD_BEEF_0000_0001;
        repeat (2) tick();
        rst_l[1] = 1;
        tick();
        d_req[1] = 0;
        repeat (3) tick();

        // Data request raised and withdrawn while a fetch read is outstanding.
        if_req[1] = 1; if_addr[1] = 64'h60;
        tick();
        if_req[1] = 0;
        d_req[1] = 1; d_we[1] = 0; d_addr[1] = 64'h70;
        repeat (2) tick();
        d_req[1] = 0;
        repeat (2) tick();

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < NI; k++) begin
                if (!rst_l[k]) rst_l[k] = ($urandom_range(2) == 0);
                else if ($urandom_range(299) == 0) rst_l[k] = 0;
                rand_req(k);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares one synchronous BRAM port between instruction fetch and data load/store requesters. It sits between the fetch stage, the load/store path, and a unified memory macro with fixed read latency. It grants one access at a time and tracks the single outstanding read. It routes read data back to the owner with a one-cycle `rvalid` pulse. Data accesses win by default; a starvation guard forces a fetch grant after a bounded burst of data grants.

## Interface
- `MEM_LATENCY`, default 1: BRAM read latency in cycles; legal values are 1 and 2.
- `MAX_D_BURST`, default 4: maximum consecutive data grants while `if_req` is pending; legal range 1..15.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held with `if_addr` stable until `if_gnt`.
- `if_addr`  in  64  fetch byte address, word-aligned.
- `if_gnt`  out  1  fetch request accepted this cycle.
- `if_rvalid`  out  1  one-cycle pulse; `if_rdata` is valid.
- `if_rdata`  out  32  instruction word.
- `d_req`  in  1  data request; held with payload stable until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  64  data byte address.
- `d_wdata`  in  64  store data.
- `d_func3`  in  3  access size/sign, passed to memory.
- `d_gnt`  out  1  data request accepted; for stores this is completion.
- `d_rvalid`  out  1  one-cycle pulse; `d_rdata` is valid.
- `d_rdata`  out  64  load data.
- `mem_en`, `mem_we`  out  1 each  memory enable and write enable.
- `mem_addr`  out  64  memory address.
- `mem_wdata`  out  64  memory write data.
- `mem_func3`  out  3  memory access size.
- `mem_rdata`  in  64  memory read data, valid `MEM_LATENCY` cycles after `mem_en`.
- `busy`  out  1  a read is outstanding.

## Operation
- **FSM states:** IDLE and RD_WAIT.
- **Grants in IDLE:**
  - Only IDLE issues grants.
  - With no request, no grant and all `mem_*` outputs are 0.
  - With one requester, that requester is granted.
  - With both requesting, data wins unless `burst_cnt == MAX_D_BURST`; in that case fetch wins.
- **Starvation guard (`burst_cnt`, 4 bits):**
  - Increments on a data grant while `if_req` = 1.
  - Clears on a fetch grant, or on a data grant while `if_req` = 0.
  - Saturates at `MAX_D_BURST`.
- **Grant cycle (combinational):**
  - `mem_en` = 1.
  - `mem_we`, `mem_addr`, `mem_wdata`, `mem_func3` are driven from the winner's payload.
  - Fetch grants drive `mem_we` = 0 and `mem_func3` = 3'b010.
- **After a grant:**
  - A store grant stays in IDLE; the next grant can issue the following cycle.
  - A read grant (fetch, or data with `d_we` = 0) registers `owner` and `addr[2]`, loads `lat_cnt = MEM_LATENCY-1`, and moves to RD_WAIT.
- **RD_WAIT:**
  - No grants; `busy` = 1.
  - `lat_cnt` decrements each cycle while it is nonzero.
  - The cycle `lat_cnt` is 0 in RD_WAIT is the return cycle.
  - Return cycle: pulse the owner's `rvalid` for one cycle and go to IDLE.
- **Read-data routing:**
  - `if_rdata` = `mem_rdata[31:0]` when the latched `addr[2]` = 0, otherwise `mem_rdata[63:32]`.
  - `d_rdata` = `mem_rdata` unchanged; sign/size handling belongs to the memory.
- **Boundary conditions:**
  - A requester dropping `req` before `gnt` is legal; no access occurs.
  - A new request arriving during RD_WAIT waits in its requester.
  - Requests are not checked for misalignment.
- **Reset:**
  - Reset asserted mid-read discards the outstanding read; no `rvalid` ever follows.
  - Reset state: IDLE, `burst_cnt` = 0, `owner` = 0.
  - Every output is 0 during reset.

## Timing
- Grant-to-rvalid latency is exactly `MEM_LATENCY` cycles: grant at T, `rvalid` at T+`MEM_LATENCY`.
- Read throughput: one read per `MEM_LATENCY`+1 cycles.
- Store throughput: one store per cycle.
- The earliest grant after a read's `rvalid` is the following cycle.
- `if_gnt` and `d_gnt` are never high in the same cycle.
- `if_rvalid` and `d_rvalid` are never high in the same cycle.
- `gnt` and `mem_*` are combinational from requests and state; `rvalid`, `busy` and `owner` are registered.
- Reset deassertion is synchronised by the caller; the first grant is possible on the first rising edge with `reset` = 1.

## Structure
- Shared package `mem_pkg` holds:
  - the state encoding (IDLE = 1'b0, RD_WAIT = 1'b1);
  - the owner encoding (OWN_IF = 0, OWN_D = 1);
  - the constant `FUNC3_WORD = 3'b010`.
- One sub-module, `arb_starve_guard`, holds `burst_cnt` and the priority decision.
  - Inputs: `if_req`, `d_req`, `grant_en`.
  - Outputs: `sel_if`, `sel_d`.
- The top level holds the FSM, the latency counter, the owner/address latches and the muxes.

## Test plan
- **Lone fetch.** `if_req` at `if_addr` = 0x10 with `mem_rdata` = 0xAAAA_BBBB_CCCC_DDDD, `MEM_LATENCY` = 1.
  - `if_gnt` at T, `if_rvalid` at T+1, `if_rdata` = 0xCCCC_DDDD.
  - `if_addr` = 0x14 instead returns `if_rdata` = 0xAAAA_BBBB.
- **Simultaneous requests.** `if_req` and `d_req` (load) asserted in the same cycle.
  - `d_gnt` first.
  - `busy` high 1 cycle, `d_rvalid` at T+1.
  - `if_gnt` at T+2.
- **Starvation guard.** `if_req` held, back-to-back stores on `d_req`, `MAX_D_BURST` = 4.
  - Four `d_gnt` cycles, then `if_gnt` on the fifth grant.
  - `burst_cnt` returns to 0 after the fetch grant.
- **Latency 2.** `MEM_LATENCY` = 2, load at T.
  - `busy` high T+1..T+2.
  - `d_rvalid` only at T+2.
  - No grant issued at T+1 or T+2 despite a pending `if_req`.
- **Reset mid-read.** Pull `reset` low at T+1 of a `MEM_LATENCY` = 2 read, release at T+3.
  - No `rvalid` ever appears.
  - All outputs are 0 while `reset` is low.
  - A fresh grant follows on the first edge after release.
- **Request withdrawn.** `d_req` asserted and dropped while a fetch read is outstanding.
  - No `d_gnt` and no memory access for that request.
  - `if_rvalid` still fires at the correct cycle.
